// File: rtl/softmax_sched.sv
// Job scheduler for the softmax datapath: queues {start,end,tag} descriptors,
// sequences init/start/run for each job and returns one completion record per job.
module softmax_sched #(
  parameter int ADDRSIZE = 8,
  parameter int QDEPTH   = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDRSIZE-1:0]     req_start_addr,
  input  logic [ADDRSIZE-1:0]     req_end_addr,
  input  logic [3:0]              req_tag,
  output logic                    sm_init,
  output logic                    sm_start,
  output logic [ADDRSIZE-1:0]     sm_start_addr,
  output logic [ADDRSIZE-1:0]     sm_end_addr,
  input  logic                    sm_done,
  output logic                    cmp_valid,
  input  logic                    cmp_ready,
  output logic [3:0]              cmp_tag,
  output logic                    cmp_err,
  output logic                    busy,
  output logic [$clog2(QDEPTH):0] qcount
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, INIT, LAUNCH, RUN, REPORT} state_t;

  state_t              state, state_nxt;
  logic [ADDRSIZE-1:0] q_start [QDEPTH];
  logic [ADDRSIZE-1:0] q_end   [QDEPTH];
  logic [3:0]          q_tag   [QDEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [TW-1:0]       run_cnt;
  logic                push, pop, head_bad, err_nxt;

  // Readiness depends only on the registered occupancy, so a same-cycle pop never opens it
  assign req_ready = !reset && (count != CW'(QDEPTH));
  assign push      = req_valid && req_ready;
  assign head_bad  = q_end[rd_ptr] < q_start[rd_ptr];
  assign qcount    = count;
  assign busy      = !reset && ((state != IDLE) || (count != '0));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    sm_init   = 1'b0;
    sm_start  = 1'b0;
    cmp_valid = 1'b0;
    err_nxt   = cmp_err;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          err_nxt   = head_bad;
          state_nxt = head_bad ? REPORT : INIT;
        end
      end
      INIT: begin
        sm_init   = 1'b1;
        state_nxt = LAUNCH;
      end
      LAUNCH: begin
        sm_start  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        // First RUN cycle ignores sm_done: the datapath may still show the previous job's level
        if ((run_cnt != '0) && sm_done) begin
          err_nxt   = 1'b0;
          state_nxt = REPORT;
        end else if (run_cnt == TW'(TIMEOUT - 1)) begin
          sm_init   = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        cmp_valid = 1'b1;
        if (cmp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      pop       = 1'b0;
      sm_init   = 1'b1;
      sm_start  = 1'b0;
      cmp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_start[wr_ptr] <= req_start_addr;
      q_end[wr_ptr]   <= req_end_addr;
      q_tag[wr_ptr]   <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      run_cnt       <= '0;
      sm_start_addr <= '0;
      sm_end_addr   <= '0;
      cmp_tag       <= '0;
      cmp_err       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      // Job registers load only on dequeue, which keeps the range stable through RUN
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        cmp_tag <= q_tag[rd_ptr];
        if (!head_bad) begin
          sm_start_addr <= q_start[rd_ptr];
          sm_end_addr   <= q_end[rd_ptr];
        end
      end
      count   <= count + CW'(push) - CW'(pop);
      run_cnt <= (state == RUN) ? run_cnt + TW'(1) : '0;
      cmp_err <= err_nxt;
    end
  end

endmodule
